// File: rtl/vga_text_pkg.sv
// vga_text_pkg
//   Shared definitions for the VGA text RAM writer: geometry defaults,
//   cursor field widths, the 5-bit font code type and its fixed code
//   points, the ASCII control bytes the writer acts on, and the writer
//   FSM state type.
package vga_text_pkg;

  // Default text geometry (80 x 8 cells, 640 cells fit a 10-bit address)
  localparam int COLS_DEF   = 80;
  localparam int ROWS_DEF   = 8;
  localparam int ADDR_W_DEF = 10;
  localparam int CODE_W_DEF = 5;

  // Cursor port widths
  localparam int COL_W = 7;
  localparam int ROW_W = 3;

  typedef logic [4:0] text_code_t;

  localparam text_code_t CODE_SPACE = 5'd0;
  localparam text_code_t CODE_A     = 5'd1;
  localparam text_code_t CODE_STAR  = 5'd27;
  localparam text_code_t CODE_HASH  = 5'd28;

  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_BS = 8'h08;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } wr_state_e;

endpackage

// File: rtl/ascii_to_code.sv
// ascii_to_code
//   Purely combinational map from an ASCII byte to the font code set:
//   ' '->0, 'A'..'Z'->1..26, '*'->27, '#'->28, everything else -> 0.
//   Build option TEXT_WR_LOWERCASE_EN: when defined, 'a'..'z' also map to
//   1..26; when undefined, lowercase falls through to code 0.
//   Control bytes are not filtered here; the writer decides what to do
//   with them before this code is ever used.
// Ports
//   ascii_i  in   8  ASCII byte
//   code_o   out  5  font code
module ascii_to_code
  import vga_text_pkg::*;
(
  input  logic [7:0]  ascii_i,
  output text_code_t  code_o
);

  always_comb begin
    code_o = CODE_SPACE;
    if (ascii_i >= 8'h41 && ascii_i <= 8'h5A) begin
      code_o = CODE_A + text_code_t'(ascii_i - 8'h41);
    end
`ifdef TEXT_WR_LOWERCASE_EN
    else if (ascii_i >= 8'h61 && ascii_i <= 8'h7A) begin
      code_o = CODE_A + text_code_t'(ascii_i - 8'h61);
    end
`endif
    else if (ascii_i == 8'h2A) begin
      code_o = CODE_STAR;
    end
    else if (ascii_i == 8'h23) begin
      code_o = CODE_HASH;
    end
  end

endmodule

// File: rtl/text_buffer_writer.sv
// text_buffer_writer
//   Writer side of the VGA text RAM. Accepts ASCII bytes on a valid/ready
//   handshake, maps them to font codes, maintains a text cursor and drives
//   the RAM write port. A one-cycle clr pulse clears the whole screen (one
//   cell per cycle) and homes the cursor.
//   Build option TEXT_WR_LOWERCASE_EN (in ascii_to_code): lowercase letters
//   map like uppercase when defined, otherwise they are written as 0.
// Ports
//   clk       in   1       clock, rising edge
//   rst       in   1       synchronous active-high reset
//   in_valid  in   1       in_ascii carries a byte
//   in_ready  out  1       byte accepted this cycle if in_valid (and no clr)
//   in_ascii  in   8       ASCII byte
//   clr       in   1       pulse: clear screen, home cursor
//   wr_addr   out  ADDR_W  text RAM write address (col + row*COLS)
//   wr_data   out  CODE_W  text RAM write data
//   wr_en     out  1       text RAM write enable
//   busy      out  1       clear in progress
//   cur_col   out  7       cursor column
//   cur_row   out  3       cursor row
module text_buffer_writer
  import vga_text_pkg::*;
#(
  parameter int COLS   = COLS_DEF,
  parameter int ROWS   = ROWS_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CODE_W = CODE_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_ascii,
  input  logic              clr,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [CODE_W-1:0] wr_data,
  output logic              wr_en,
  output logic              busy,
  output logic [COL_W-1:0]  cur_col,
  output logic [ROW_W-1:0]  cur_row
);

  localparam int CELLS = COLS * ROWS;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  wr_state_e          state_q, state_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  // One bit wider than the address so it can hold CELLS itself, which
  // marks "all cells written" even when CELLS == 2**ADDR_W.
  logic [ADDR_W:0]    clr_cnt_q, clr_cnt_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [CODE_W-1:0]  wr_data_q, wr_data_d;

  text_code_t         code;
  logic [ROW_W-1:0]   row_inc;

  ascii_to_code u_map (
    .ascii_i (in_ascii),
    .code_o  (code)
  );

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [COL_W-1:0] c,
                                                  input logic [ROW_W-1:0] r);
    return ADDR_W'(r) * ADDR_W'(COLS) + ADDR_W'(c);
  endfunction

  // Next row with wrap to the top (no scrolling)
  assign row_inc = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    clr_cnt_d = clr_cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    case (state_q)
      IDLE: begin
        if (clr) begin
          // First clear write is issued right away so busy and wr_en cover
          // exactly the same CELLS cycles.
          state_d   = CLEAR;
          wr_en_d   = 1'b1;
          wr_addr_d = '0;
          wr_data_d = '0;
          clr_cnt_d = (ADDR_W+1)'(1);
        end else if (in_valid) begin
          if (in_ascii >= 8'h20) begin
            wr_en_d   = 1'b1;
            wr_addr_d = cell_addr(col_q, row_q);
            wr_data_d = CODE_W'(code);
            if (col_q == COL_LAST) begin
              col_d = '0;
              row_d = row_inc;
            end else begin
              col_d = col_q + COL_W'(1);
            end
          end else if (in_ascii == ASCII_LF) begin
            col_d = '0;
            row_d = row_inc;
          end else if (in_ascii == ASCII_CR) begin
            col_d = '0;
          end else if (in_ascii == ASCII_BS) begin
            if (col_q != '0) begin
              col_d     = col_q - COL_W'(1);
              wr_en_d   = 1'b1;
              wr_addr_d = cell_addr(col_q - COL_W'(1), row_q);
              wr_data_d = '0;
            end else if (row_q != '0) begin
              col_d     = COL_LAST;
              row_d     = row_q - ROW_W'(1);
              wr_en_d   = 1'b1;
              wr_addr_d = cell_addr(COL_LAST, row_q - ROW_W'(1));
              wr_data_d = '0;
            end
          end
        end
      end

      CLEAR: begin
        if (clr_cnt_q == (ADDR_W+1)'(CELLS)) begin
          state_d = IDLE;
          col_d   = '0;
          row_d   = '0;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = clr_cnt_q[ADDR_W-1:0];
          wr_data_d = '0;
          clr_cnt_d = clr_cnt_q + (ADDR_W+1)'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      col_q     <= '0;
      row_q     <= '0;
      clr_cnt_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      clr_cnt_q <= clr_cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q == CLEAR);
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign cur_col  = col_q;
  assign cur_row  = row_q;

endmodule
